// File: rtl/loss_run_sequencer.sv
// Loss-measurement run sequencer: resets the loss calculator, gates frames into it,
// captures per-run counts, hands them to a consumer and accumulates sequence totals.
module loss_run_sequencer #(
    parameter int unsigned NUM_RUNS    = 4,
    parameter int unsigned RST_CYC     = 4,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        rx_valid,
    output logic        calc_valid,
    output logic        calc_rst,
    input  logic        calc_done,
    input  logic [15:0] calc_ok,
    input  logic [15:0] calc_ng,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_run,
    output logic [15:0] res_ok,
    output logic [15:0] res_ng,
    output logic        res_timeout,
    output logic [31:0] tot_ok,
    output logic [31:0] tot_ng,
    output logic        busy,
    output logic        seq_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CRST = 3'd1;
    localparam logic [2:0] S_MEAS = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_REPT = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [7:0]  LAST_RUN = 8'(NUM_RUNS - 1);
    localparam logic [3:0]  RST_LAST = 4'(RST_CYC - 1);
    localparam logic [23:0] TMO_LAST = TIMEOUT_CYC - 24'd1;

    logic [2:0]  state_q, state_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [23:0] tcnt_q, tcnt_d;
    logic [7:0]  run_q, run_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  res_run_q, res_run_d;
    logic [15:0] res_ok_q, res_ok_d;
    logic [15:0] res_ng_q, res_ng_d;
    logic        res_tmo_q, res_tmo_d;
    logic [31:0] tot_ok_q, tot_ok_d;
    logic [31:0] tot_ng_q, tot_ng_d;
    logic [32:0] sum_ok, sum_ng;

    // One extra bit catches the carry used for saturation.
    assign sum_ok = {1'b0, tot_ok_q} + {17'd0, calc_ok};
    assign sum_ng = {1'b0, tot_ng_q} + {17'd0, calc_ng};

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        tcnt_d    = tcnt_q;
        run_d     = run_q;
        tmo_d     = tmo_q;
        res_run_d = res_run_q;
        res_ok_d  = res_ok_q;
        res_ng_d  = res_ng_q;
        res_tmo_d = res_tmo_q;
        tot_ok_d  = tot_ok_q;
        tot_ng_d  = tot_ng_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        tot_ok_d = 32'd0;
                        tot_ng_d = 32'd0;
                        run_d    = 8'd0;
                        rcnt_d   = 4'd0;
                        state_d  = S_CRST;
                    end
                end
                S_CRST: begin
                    if (rcnt_q == RST_LAST) begin
                        tcnt_d  = 24'd0;
                        state_d = S_MEAS;
                    end else begin
                        rcnt_d = rcnt_q + 4'd1;
                    end
                end
                S_MEAS: begin
                    // A completion in the same cycle as the timeout is a clean finish.
                    if (calc_done) begin
                        tmo_d   = 1'b0;
                        state_d = S_CAPT;
                    end else if (tcnt_q == TMO_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = S_CAPT;
                    end else begin
                        tcnt_d = tcnt_q + 24'd1;
                    end
                end
                S_CAPT: begin
                    res_ok_d  = calc_ok;
                    res_ng_d  = calc_ng;
                    res_run_d = run_q;
                    res_tmo_d = tmo_q;
                    tot_ok_d  = sum_ok[32] ? 32'hFFFF_FFFF : sum_ok[31:0];
                    tot_ng_d  = sum_ng[32] ? 32'hFFFF_FFFF : sum_ng[31:0];
                    state_d   = S_REPT;
                end
                S_REPT: begin
                    if (res_ready) begin
                        if (res_run_q == LAST_RUN) begin
                            state_d = S_FIN;
                        end else begin
                            run_d   = run_q + 8'd1;
                            rcnt_d  = 4'd0;
                            state_d = S_CRST;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rcnt_q    <= 4'd0;
            tcnt_q    <= 24'd0;
            run_q     <= 8'd0;
            tmo_q     <= 1'b0;
            res_run_q <= 8'd0;
            res_ok_q  <= 16'd0;
            res_ng_q  <= 16'd0;
            res_tmo_q <= 1'b0;
            tot_ok_q  <= 32'd0;
            tot_ng_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            tcnt_q    <= tcnt_d;
            run_q     <= run_d;
            tmo_q     <= tmo_d;
            res_run_q <= res_run_d;
            res_ok_q  <= res_ok_d;
            res_ng_q  <= res_ng_d;
            res_tmo_q <= res_tmo_d;
            tot_ok_q  <= tot_ok_d;
            tot_ng_q  <= tot_ng_d;
        end
    end

    assign calc_valid  = (state_q == S_MEAS) & rx_valid;
    assign calc_rst    = (state_q == S_IDLE) | (state_q == S_CRST) | (state_q == S_FIN);
    assign res_valid   = (state_q == S_REPT);
    assign busy        = (state_q != S_IDLE) & (state_q != S_FIN);
    assign seq_done    = (state_q == S_FIN);
    assign res_run     = res_run_q;
    assign res_ok      = res_ok_q;
    assign res_ng      = res_ng_q;
    assign res_timeout = res_tmo_q;
    assign tot_ok      = tot_ok_q;
    assign tot_ng      = tot_ng_q;

endmodule

// File: tb/tb_loss_run_sequencer.sv
// Directed bench for loss_run_sequencer: a cycle table for a two-run sequence plus
// hand sequences for timeout, back-pressure, abort, saturation and mid-run reset.
module tb_loss_run_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, rx_valid, calc_done, res_ready;
    logic [15:0] calc_ok, calc_ng;
    logic        calc_valid, calc_rst, res_valid, res_timeout, busy, seq_done;
    logic [7:0]  res_run;
    logic [15:0] res_ok, res_ng;
    logic [31:0] tot_ok, tot_ng;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    loss_run_sequencer #(.NUM_RUNS(2), .RST_CYC(4), .TIMEOUT_CYC(24'd16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rx_valid(rx_valid),
        .calc_valid(calc_valid), .calc_rst(calc_rst), .calc_done(calc_done),
        .calc_ok(calc_ok), .calc_ng(calc_ng), .res_valid(res_valid),
        .res_ready(res_ready), .res_run(res_run), .res_ok(res_ok), .res_ng(res_ng),
        .res_timeout(res_timeout), .tot_ok(tot_ok), .tot_ng(tot_ng),
        .busy(busy), .seq_done(seq_done)
    );

    typedef struct {
        logic        st, ab, rx, dn;
        logic [15:0] ok, ng;
        logic        rdy;
        logic        e_busy, e_sd, e_crst, e_cv, e_rv;
        logic [7:0]  e_run;
        logic [15:0] e_rok, e_rng;
        logic [31:0] e_tok, e_tng;
        logic        e_tmo;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(input logic st, ab, rx, dn, input logic [15:0] ok, ng,
                                input logic rdy, bz, sd, cr, cv, rv, input logic [7:0] run,
                                input logic [15:0] rok, rng, input logic [31:0] tok, tng,
                                input logic tmo);
        vec_t v;
        v.st = st; v.ab = ab; v.rx = rx; v.dn = dn; v.ok = ok; v.ng = ng; v.rdy = rdy;
        v.e_busy = bz; v.e_sd = sd; v.e_crst = cr; v.e_cv = cv; v.e_rv = rv;
        v.e_run = run; v.e_rok = rok; v.e_rng = rng; v.e_tok = tok; v.e_tng = tng;
        v.e_tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m;
        // start, abort, rx, done, ok, ng, ready | busy, sdone, crst, cv, rv, run, rok, rng, tok, tng, tmo
        tv[0] = mk(1,0,0,0, 0,0, 0, 0,0,1,0,0, 0, 0,0, 0,0, 0);
        for (int i = 1; i <= 4; i++)
            tv[i] = mk(0,0,1,0, 0,0, 0, 1,0,1,0,0, 0, 0,0, 0,0, 0);
        tv[5]  = mk(0,0,1,0, 0,0,    0, 1,0,0,1,0, 0, 0,0, 0,0, 0);
        tv[6]  = mk(1,0,0,0, 0,0,    0, 1,0,0,0,0, 0, 0,0, 0,0, 0);
        tv[7]  = mk(0,0,1,1, 100,3,  0, 1,0,0,1,0, 0, 0,0, 0,0, 0);
        tv[8]  = mk(0,0,1,1, 100,3,  1, 1,0,0,0,0, 0, 0,0, 0,0, 0);
        tv[9]  = mk(0,0,0,0, 100,3,  0, 1,0,0,0,1, 0, 100,3, 100,3, 0);
        tv[10] = mk(0,0,0,0, 0,0,    1, 1,0,0,0,1, 0, 100,3, 100,3, 0);
        for (int i = 11; i <= 14; i++)
            tv[i] = mk(0,0,1,0, 50,7, 0, 1,0,1,0,0, 0, 100,3, 100,3, 0);
        tv[15] = mk(0,0,0,1, 50,7,   0, 1,0,0,0,0, 0, 100,3, 100,3, 0);
        tv[16] = mk(0,0,1,0, 50,7,   0, 1,0,0,0,0, 0, 100,3, 100,3, 0);
        tv[17] = mk(0,0,0,0, 0,0,    1, 1,0,0,0,1, 1, 50,7, 150,10, 0);
        tv[18] = mk(0,0,1,0, 0,0,    1, 0,1,1,0,0, 1, 50,7, 150,10, 0);
        tv[19] = mk(0,0,0,0, 0,0,    0, 0,1,1,0,0, 1, 50,7, 150,10, 0);

        // Reset with start/abort asserted: reset must win.
        rst = 1'b0; start = 1'b1; abort = 1'b1; rx_valid = 1'b1; calc_done = 1'b0;
        calc_ok = 16'd0; calc_ng = 16'd0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0;
        #1;
        chk("reset calc_rst", calc_rst, 1);
        chk("reset busy/sd/rv/cv", {busy, seq_done, res_valid, calc_valid}, 0);
        chk("reset res_run/tmo", {res_run, res_timeout}, 0);
        chk("reset res_ok/ng", {res_ok, res_ng}, 0);
        chk("reset tot_ok", tot_ok, 0);
        chk("reset tot_ng", tot_ng, 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = tv[i].st; abort = tv[i].ab; rx_valid = tv[i].rx; calc_done = tv[i].dn;
            calc_ok = tv[i].ok; calc_ng = tv[i].ng; res_ready = tv[i].rdy;
            #1;
            chk($sformatf("v%0d busy", i), busy, tv[i].e_busy);
            chk($sformatf("v%0d seq_done", i), seq_done, tv[i].e_sd);
            chk($sformatf("v%0d calc_rst", i), calc_rst, tv[i].e_crst);
            chk($sformatf("v%0d calc_valid", i), calc_valid, tv[i].e_cv);
            chk($sformatf("v%0d res_valid", i), res_valid, tv[i].e_rv);
            chk($sformatf("v%0d res_run", i), res_run, tv[i].e_run);
            chk($sformatf("v%0d res_ok/ng", i), {res_ok, res_ng}, {tv[i].e_rok, tv[i].e_rng});
            chk($sformatf("v%0d tot_ok", i), tot_ok, tv[i].e_tok);
            chk($sformatf("v%0d tot_ng", i), tot_ng, tv[i].e_tng);
            chk($sformatf("v%0d res_timeout", i), res_timeout, tv[i].e_tmo);
        end

        // Restart from FINISH, never complete: timeout after 16 MEASURE cycles.
        @(negedge clk);
        start = 1'b1; rx_valid = 1'b1; calc_done = 1'b0; calc_ok = 16'd7; calc_ng = 16'd2;
        res_ready = 1'b0;
        #1;
        chk("finish seq_done", seq_done, 1);
        n = 0;
        do begin
            @(negedge clk); start = 1'b0; #1; n++;
        end while (!calc_valid && n < 40);
        chk("start to calc_valid latency", n, 5);
        chk("tot_ok cleared on restart", tot_ok, 0);
        m = 1;
        while (m < 100) begin
            @(negedge clk); #1;
            if (!calc_valid) break;
            m++;
        end
        chk("timeout measure cycles", m, 16);
        chk("capture res_valid", res_valid, 0);
        @(negedge clk); #1;
        chk("timeout res_valid", res_valid, 1);
        chk("timeout res_timeout", res_timeout, 1);
        chk("timeout res_ok/ng", {res_ok, res_ng}, {16'd7, 16'd2});
        chk("timeout tot", {tot_ok[15:0], tot_ng[15:0]}, {16'd7, 16'd2});

        // Back-pressure: result held, no new run.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            chk($sformatf("stall %0d", k), {res_valid, calc_rst, res_run, res_ok},
                {1'b1, 1'b0, 8'd0, 16'd7});
        end
        @(negedge clk); res_ready = 1'b1; #1;
        chk("handshake res_valid", res_valid, 1);
        @(negedge clk); res_ready = 1'b0; #1;
        chk("run1 crst", {calc_rst, res_valid, busy}, 3'b101);
        repeat (4) @(negedge clk);
        #1;
        chk("run1 measure calc_valid", calc_valid, 1);

        // Abort mid-MEASURE.
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; #1;
        chk("abort calc_valid", calc_valid, 0);
        chk("abort calc_rst/busy/sd", {calc_rst, busy, seq_done}, 3'b100);
        chk("abort tot kept", {tot_ok[15:0], tot_ng[15:0]}, {16'd7, 16'd2});
        chk("abort res kept", {res_timeout, res_ok}, {1'b1, 16'd7});

        // Saturation of the accumulated received count.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        force dut.tot_ok_q = 32'hFFFF_FFF0;
        calc_done = 1'b1; calc_ok = 16'h0100; calc_ng = 16'd1;
        #1;
        chk("sat measure calc_valid", calc_valid, 1);
        release dut.tot_ok_q;
        @(negedge clk); #1;
        chk("sat preload", tot_ok, 32'hFFFF_FFF0);
        @(negedge clk); #1;
        chk("sat tot_ok", tot_ok, 32'hFFFF_FFFF);
        chk("sat tot_ng", tot_ng, 1);
        chk("sat res", {res_valid, res_timeout, res_ok}, {1'b1, 1'b0, 16'h0100});

        // Reset mid-REPORT while abort and start are asserted.
        rst = 1'b0; abort = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b1; abort = 1'b0; start = 1'b0; #1;
        chk("midrst calc_rst/cv/rv", {calc_rst, calc_valid, res_valid}, 3'b100);
        chk("midrst busy/sd/tmo", {busy, seq_done, res_timeout}, 0);
        chk("midrst res", {res_ok, res_ng}, 0);
        chk("midrst res_run", res_run, 0);
        chk("midrst tot_ok", tot_ok, 0);
        chk("midrst tot_ng", tot_ng, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
